// File: rtl/rr_arb4_if.sv
// Handshake bundle between the requesters and the rr_arb4 round-robin arbiter.
// master: requester side; slave: arbiter side.
interface rr_arb4_if;
    logic [3:0] req;
    logic       done;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    modport master (
        output req,
        output done,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );
endinterface

// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter producing the registered grant index for the deshif decoder.
// Optional forced release after HOLD_MAX grant cycles when RR_ARB_TIMEOUT_EN is defined.
module rr_arb4 #(
    parameter int HOLD_MAX = 15
) (
    input  logic     clk,
    input  logic     reset,
    rr_arb4_if.slave bus
);
    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t     r_state, w_state_nxt;
    logic [1:0] r_ptr, w_ptr_nxt;
    logic [1:0] r_gnt_idx, w_gnt_idx_nxt;
    logic       r_gnt_valid, w_gnt_valid_nxt;
    logic       r_timeout, w_timeout_nxt;
    logic [1:0] w_winner;
    logic       w_any_req;
    logic       w_owner_req;
    logic       w_to_hit;
    logic       w_release;

    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("rr_arb4: HOLD_MAX must be in 1..255");
    end

    // Lowest rotated offset from r_ptr wins, so scan offsets high to low.
    always_comb begin
        w_winner = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (bus.req[r_ptr + 2'(k)]) begin
                w_winner = r_ptr + 2'(k);
            end
        end
    end

    assign w_any_req   = |bus.req;
    assign w_owner_req = bus.req[r_gnt_idx];

`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    logic [7:0] r_hcnt, w_hcnt_nxt;

    assign w_to_hit = (r_hcnt == HOLD_LAST);

    always_comb begin
        w_hcnt_nxt = r_hcnt;
        if (r_state == S_IDLE) begin
            w_hcnt_nxt = 8'd0;
        end else if (!w_release && r_hcnt != 8'hFF) begin
            w_hcnt_nxt = r_hcnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hcnt <= 8'd0;
        end else begin
            r_hcnt <= w_hcnt_nxt;
        end
    end
`else
    assign w_to_hit = 1'b0;
`endif

    assign w_release = bus.done | ~w_owner_req | w_to_hit;

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_gnt_idx_nxt   = r_gnt_idx;
        w_gnt_valid_nxt = r_gnt_valid;
        w_timeout_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt     = S_GRANT;
                    w_gnt_idx_nxt   = w_winner;
                    w_gnt_valid_nxt = 1'b1;
                end
            end
            S_GRANT: begin
                // gnt_idx is left alone on release so it still names the last owner.
                if (w_release) begin
                    w_state_nxt     = S_IDLE;
                    w_gnt_valid_nxt = 1'b0;
                    w_ptr_nxt       = r_gnt_idx + 2'd1;
                    w_timeout_nxt   = w_to_hit & ~bus.done & w_owner_req;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ptr       <= 2'd0;
            r_gnt_idx   <= 2'd0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_gnt_idx   <= w_gnt_idx_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    assign bus.gnt_idx   = r_gnt_idx;
    assign bus.gnt_valid = r_gnt_valid;
    assign bus.timeout   = r_timeout;
endmodule

// File: doc/rr_arb4.md
# rr_arb4

Four-requester round-robin arbiter that produces the 2-bit grant index driving the 2-to-4 decoder stage (`deshif`). The decoder turns `gnt_idx` into the one-hot grant bus. The arbiter registers the winner, holds the grant until the owner releases it, and rotates priority so no requester starves.

## Interface
Parameters:
- `HOLD_MAX`, default 15: maximum cycles a grant may be held before forced release. Legal range 1..255. Used only when `RR_ARB_TIMEOUT_EN` is defined.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `req`, in, 4: request per requester; `req[i]` is requester i.
- `done`, in, 1: current owner finished; sampled only in GRANT.
- `gnt_idx`, out, 2: index of the current or last owner; connects to decoder input `a`.
- `gnt_valid`, out, 1: `gnt_idx` is a live grant; gates the decoder output downstream.
- `timeout`, out, 1: one-cycle pulse when a grant is force-released.

## Operation
- Registered state:
  - FSM with states IDLE and GRANT.
  - 2-bit priority pointer `ptr`.
  - 8-bit hold counter `hcnt`.
  - Output registers `gnt_idx`, `gnt_valid`, `timeout`.
- Reset values:
  - state = IDLE, `ptr` = 0, `hcnt` = 0.
  - `gnt_idx` = 2'b00, `gnt_valid` = 0, `timeout` = 0.
- IDLE:
  - If `req` == 0, remain in IDLE.
  - Otherwise the winner is the first set bit scanning `ptr`, `ptr`+1, ... modulo 4 (3 wraps to 0).
  - On a win: `gnt_idx` ← winner, `gnt_valid` ← 1, `hcnt` ← 0, go to GRANT.
- GRANT: release occurs when any of these is true at the edge:
  - `done` == 1;
  - `req[gnt_idx]` == 0;
  - timeout: `hcnt` == `HOLD_MAX`-1 (only with `RR_ARB_TIMEOUT_EN`).
- On release:
  - `gnt_valid` ← 0, `ptr` ← `gnt_idx`+1 (mod 4), go to IDLE.
  - `gnt_idx` keeps its value.
  - `timeout` ← 1 only if the release cause was the timeout and neither `done` nor the `req` drop was present.
- Otherwise, while in GRANT: `hcnt` ← `hcnt`+1, saturating at 255.
- Requests from other requesters during GRANT are ignored; they compete at the next IDLE.
- Multiple simultaneous release causes produce exactly one release. `ptr` advances once.
- `timeout` is high for exactly one cycle, then returns to 0.
- Reset during GRANT: all registers return to reset values at that edge. No release side effects; `ptr` becomes 0, not `gnt_idx`+1.

## Timing
- Grant latency: `req` sampled at edge k in IDLE → `gnt_valid` = 1 after edge k.
- Release latency: `done` sampled at edge m → `gnt_valid` = 0 after edge m.
- Gap between grants: at least one IDLE cycle. The next grant is visible after edge m+1 at the earliest.
- Maximum grant length with timeout: `HOLD_MAX` cycles of `gnt_valid` = 1. `timeout` is high in the cycle following the last grant cycle.
- `req` and `done` are synchronous to `clk`. No combinational path from inputs to outputs.
- `done` is ignored in IDLE.

## Configuration
- `RR_ARB_TIMEOUT_EN` defined:
  - `hcnt` is implemented.
  - Forced release after `HOLD_MAX` cycles; `timeout` pulses as above.
- Not defined:
  - No hold counter.
  - A grant lasts until `done` or a `req` drop; it may last indefinitely.
  - `timeout` is tied to 0.
  - `HOLD_MAX` is unused.

## Test plan
- Reset then idle: `reset`=1 for 2 cycles, `req`=4'b0000 for 5 cycles → `gnt_valid`=0, `gnt_idx`=2'b00, `timeout`=0 throughout.
- Single requester: `req`=4'b0100 → `gnt_idx`=2, `gnt_valid`=1 one cycle later. `done`=1 for one cycle → `gnt_valid`=0 next cycle. Decoder output reads 4'b0100 while valid.
- Rotation: `req`=4'b1111 held, `done` pulsed after each grant → `gnt_idx` sequence 0,1,2,3,0 with one `gnt_valid`=0 cycle between grants.
- Request drop and wrap: grant to 3 with `req`=4'b1001; drop `req[3]` → release. Next grant goes to 0 (pointer wrapped 3→0).
- Timeout (macro defined, `HOLD_MAX`=4): `req`=4'b0010 held, `done`=0 → `gnt_valid` high exactly 4 cycles, then `timeout`=1 for 1 cycle. Without the macro, `gnt_valid` stays high for 20+ cycles and `timeout` stays 0.
- Reset mid-grant plus simultaneous causes:
  - `done`=1 and `req[gnt_idx]`=0 on the same edge → one release; `ptr` advances by 1 only.
  - `reset` asserted during GRANT with `req`=4'b1111 → outputs return to reset values. The next grant after reset goes to requester 0.
